// File: rtl/canny_stream_sobel.sv
// Streaming 3x3 Sobel gradient/direction stage: raster pixels in, saturated
// magnitude plus quantised edge-normal direction out for every interior pixel.
module canny_stream_sobel #(
   parameter int DW        = 8,
   parameter int IMG_W     = 200,
   parameter int IMG_H     = 200,
   parameter int MAG_SHIFT = 3
) (
   input  logic          tclk,
   input  logic          rst_b,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_sof,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_mag,
   output logic [7:0]    out_dir,
   output logic          out_eol,
   output logic          out_eof,
   output logic          sof_err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int GW = DW + 4;
   localparam int SW = DW + 5;
   localparam int TW = DW + 8;

   typedef enum logic [7:0] {
      DIR_0   = 8'd0,
      DIR_45  = 8'd45,
      DIR_90  = 8'd90,
      DIR_135 = 8'd135
   } dir_e;

   logic                 adv, acc, launch, col_last, row_last;
   logic [CW-1:0]        col_q, col_c, col_d;
   logic [RW-1:0]        row_q, row_c, row_d;
   logic [DW-1:0]        lb0_q [IMG_W];
   logic [DW-1:0]        lb1_q [IMG_W];
   logic [DW-1:0]        win_q [3][3];
   logic                 win_vld_q, win_eol_q, win_eof_q;
   logic                 s1_vld_q, s1_eol_q, s1_eof_q;
   logic signed [GW-1:0] gx_c, gy_c, s1_gx_q, s1_gy_q, fx_c;
   logic [GW-1:0]        agx_c, agy_c;
   logic [SW-1:0]        sum_c, m_c;
   logic [TW-1:0]        fy2_c, ax_c, ax5_c;
   logic [DW-1:0]        mag_c, out_mag_q;
   dir_e                 dir_c, out_dir_q;
   logic                 out_valid_q, out_eol_q, out_eof_q, sof_err_q;

   function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] v);
      return signed'({4'b0000, v});
   endfunction

   // Position of the pixel being offered; in_sof overrides the counters.
   always_comb begin
      adv      = !out_valid_q || out_ready;
      acc      = in_valid && adv;
      col_c    = in_sof ? '0 : col_q;
      row_c    = in_sof ? '0 : row_q;
      col_last = (col_c == CW'(IMG_W - 1));
      row_last = (row_c == RW'(IMG_H - 1));
      col_d    = col_last ? '0 : col_c + 1'b1;
      row_d    = !col_last ? row_c : (row_last ? '0 : row_c + 1'b1);
      launch   = (row_c >= RW'(2)) && (col_c >= CW'(2));
   end

   always_comb begin
      gx_c = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
      gy_c = (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]))
           - (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]));
   end

   // |fx| equals |Gx| and fy equals |Gy|, so only the sign of fx is needed.
   always_comb begin
      agx_c = s1_gx_q[GW-1] ? $unsigned(-s1_gx_q) : $unsigned(s1_gx_q);
      agy_c = s1_gy_q[GW-1] ? $unsigned(-s1_gy_q) : $unsigned(s1_gy_q);
      sum_c = SW'(agx_c) + SW'(agy_c);
      m_c   = sum_c >> MAG_SHIFT;
      mag_c = (|m_c[SW-1:DW]) ? '1 : m_c[DW-1:0];
      fx_c  = s1_gy_q[GW-1] ? -s1_gx_q : s1_gx_q;
      fy2_c = TW'(agy_c) << 1;
      ax_c  = TW'(agx_c);
      ax5_c = (ax_c << 2) + ax_c;
      if (fy2_c <= ax_c)       dir_c = DIR_0;
      else if (fy2_c <= ax5_c) dir_c = fx_c[GW-1] ? DIR_135 : DIR_45;
      else                     dir_c = DIR_90;
   end

   always_ff @(posedge tclk) begin
      if (acc) begin
         lb0_q[col_c] <= lb1_q[col_c];
         lb1_q[col_c] <= in_data;
         for (int unsigned r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= lb0_q[col_c];
         win_q[1][2] <= lb1_q[col_c];
         win_q[2][2] <= in_data;
      end
      if (adv) begin
         s1_gx_q <= gx_c;
         s1_gy_q <= gy_c;
      end
   end

   always_ff @(posedge tclk or negedge rst_b) begin
      if (!rst_b) begin
         col_q       <= '0;
         row_q       <= '0;
         sof_err_q   <= 1'b0;
         win_vld_q   <= 1'b0;
         win_eol_q   <= 1'b0;
         win_eof_q   <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_mag_q   <= '0;
         out_dir_q   <= DIR_0;
         out_eol_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         if (acc) begin
            col_q <= col_d;
            row_q <= row_d;
            if (in_sof && ((col_q != '0) || (row_q != '0))) sof_err_q <= 1'b1;
         end
         if (adv) begin
            win_vld_q   <= acc && launch;
            win_eol_q   <= col_last;
            win_eof_q   <= col_last && row_last;
            s1_vld_q    <= win_vld_q;
            s1_eol_q    <= win_eol_q;
            s1_eof_q    <= win_eof_q;
            out_valid_q <= s1_vld_q;
            out_mag_q   <= mag_c;
            out_dir_q   <= dir_c;
            out_eol_q   <= s1_eol_q;
            out_eof_q   <= s1_eof_q;
         end
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_mag   = out_mag_q;
   assign out_dir   = out_dir_q;
   assign out_eol   = out_eol_q;
   assign out_eof   = out_eof_q;
   assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_canny_stream_sobel.sv
// Directed bench for canny_stream_sobel on a 5x4 image; a second instance with
// MAG_SHIFT=0 shares the stimulus to exercise magnitude saturation.
module tb_canny_stream_sobel;
   localparam int W = 5;
   localparam int H = 4;
   localparam int N = W * H;

   logic       tclk = 1'b0;
   logic       rst_b;
   logic       in_valid, in_sof, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, out_eol, out_eof, sof_err;
   logic [7:0] out_mag, out_dir;
   logic       s_in_ready, s_out_valid, s_out_eol, s_out_eof, s_sof_err;
   logic [7:0] s_out_mag, s_out_dir;

   int total = 0;
   int bad   = 0;
   logic [17:0] q [$];
   logic [7:0]  qs [$];

   always #5 tclk = ~tclk;

   canny_stream_sobel #(.DW(8), .IMG_W(W), .IMG_H(H), .MAG_SHIFT(3)) dut (
      .tclk(tclk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid),
      .out_ready(out_ready), .out_mag(out_mag), .out_dir(out_dir),
      .out_eol(out_eol), .out_eof(out_eof), .sof_err(sof_err));

   canny_stream_sobel #(.DW(8), .IMG_W(W), .IMG_H(H), .MAG_SHIFT(0)) dut_sat (
      .tclk(tclk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_sof(in_sof), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_mag(s_out_mag), .out_dir(s_out_dir),
      .out_eol(s_out_eol), .out_eof(s_out_eof), .sof_err(s_sof_err));

   always @(negedge tclk) begin
      if (rst_b && out_valid && out_ready) begin
         q.push_back({out_mag, out_dir, out_eol, out_eof});
         qs.push_back(s_out_mag);
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic push(input logic [7:0] d, input logic sof);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      @(negedge tclk);
      while (!in_ready && n < 100) begin
         @(negedge tclk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout in_ready=%b required=1", in_ready);
      end
      @(posedge tclk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] img [N], input logic use_sof);
      for (int i = 0; i < N; i++) push(img[i], use_sof && (i == 0));
      repeat (6) @(posedge tclk);
      #1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge tclk);
      #1 rst_b = 1'b1;
      @(posedge tclk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
      total++; if (out_mag !== 8'd0) begin bad++; $display("FAIL rst_out_mag got=%0d required=0", out_mag); end
      total++; if (out_dir !== 8'd0) begin bad++; $display("FAIL rst_out_dir got=%0d required=0", out_dir); end
      total++; if (out_eol !== 1'b0 || out_eof !== 1'b0) begin bad++; $display("FAIL rst_eol_eof got=%b%b required=00", out_eol, out_eof); end
      total++; if (sof_err !== 1'b0) begin bad++; $display("FAIL rst_sof_err got=%b required=0", sof_err); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
   endtask

   task automatic test_flat();
      logic [7:0] img [N];
      logic [17:0] ex, got;
      foreach (img[i]) img[i] = 8'd50;
      q.delete(); qs.delete();
      send_frame(img, 1'b1);
      total++; if (q.size() != 6) begin bad++; $display("FAIL flat_count got=%0d required=6", q.size()); end
      for (int i = 0; i < 6; i++) begin
         ex  = {8'd0, 8'd0, (i % 3) == 2, i == 5};
         got = (i < q.size()) ? q[i] : 'x;
         total++; if (got !== ex) begin bad++; $display("FAIL flat_res%0d got=%h required=%h", i, got, ex); end
      end
   endtask

   task automatic test_vstep();
      logic [7:0] img [N];
      logic [7:0] em [6] = '{8'd40, 8'd40, 8'd0, 8'd40, 8'd40, 8'd0};
      logic [17:0] ex, got;
      foreach (img[i]) img[i] = ((i % W) >= 2) ? 8'd80 : 8'd0;
      q.delete(); qs.delete();
      send_frame(img, 1'b1);
      total++; if (q.size() != 6) begin bad++; $display("FAIL vstep_count got=%0d required=6", q.size()); end
      for (int i = 0; i < 6; i++) begin
         ex  = {em[i], 8'd0, (i % 3) == 2, i == 5};
         got = (i < q.size()) ? q[i] : 'x;
         total++; if (got !== ex) begin bad++; $display("FAIL vstep_res%0d got=%h required=%h", i, got, ex); end
      end
   endtask

   task automatic test_hstep();
      logic [7:0] img [N];
      logic [7:0] em [6];
      logic [7:0] ed [6];
      logic [17:0] ex, got;
      for (int m = 0; m < 2; m++) begin
         foreach (img[i]) img[i] = ((i / W) == (m == 0 ? 0 : H - 1)) ? 8'd80 : 8'd0;
         if (m == 0) begin
            em = '{8'd40, 8'd40, 8'd40, 8'd0, 8'd0, 8'd0};
            ed = '{8'd90, 8'd90, 8'd90, 8'd0, 8'd0, 8'd0};
         end else begin
            em = '{8'd0, 8'd0, 8'd0, 8'd40, 8'd40, 8'd40};
            ed = '{8'd0, 8'd0, 8'd0, 8'd90, 8'd90, 8'd90};
         end
         q.delete(); qs.delete();
         send_frame(img, 1'b1);
         total++; if (q.size() != 6) begin bad++; $display("FAIL hstep%0d_count got=%0d required=6", m, q.size()); end
         for (int i = 0; i < 6; i++) begin
            ex  = {em[i], ed[i], (i % 3) == 2, i == 5};
            got = (i < q.size()) ? q[i] : 'x;
            total++; if (got !== ex) begin bad++; $display("FAIL hstep%0d_res%0d got=%h required=%h", m, i, got, ex); end
         end
      end
   endtask

   // Single 160 at (0,2): centres (1,1),(1,2),(1,3) see it as p02, p01, p00.
   task automatic test_diag();
      logic [7:0] img [N];
      logic [7:0] em [6] = '{8'd40, 8'd40, 8'd40, 8'd0, 8'd0, 8'd0};
      logic [7:0] ed [6] = '{8'd45, 8'd90, 8'd135, 8'd0, 8'd0, 8'd0};
      logic [17:0] ex, got;
      foreach (img[i]) img[i] = (i == 2) ? 8'd160 : 8'd0;
      q.delete(); qs.delete();
      send_frame(img, 1'b1);
      total++; if (q.size() != 6) begin bad++; $display("FAIL diag_count got=%0d required=6", q.size()); end
      for (int i = 0; i < 6; i++) begin
         ex  = {em[i], ed[i], (i % 3) == 2, i == 5};
         got = (i < q.size()) ? q[i] : 'x;
         total++; if (got !== ex) begin bad++; $display("FAIL diag_res%0d got=%h required=%h", i, got, ex); end
      end
   endtask

   // 160 at (0,2) and 80 at (1,2): hits 2*fy == |fx| exactly at (1,1) and (1,3).
   task automatic build_boundary(output logic [7:0] img [N]);
      foreach (img[i]) img[i] = (i == 2) ? 8'd160 : ((i == W + 2) ? 8'd80 : 8'd0);
   endtask

   task automatic test_dir_boundary();
      logic [7:0] img [N];
      logic [7:0] em [6] = '{8'd60, 8'd40, 8'd60, 8'd20, 8'd20, 8'd20};
      logic [7:0] ed [6] = '{8'd0, 8'd90, 8'd0, 8'd45, 8'd90, 8'd135};
      logic [17:0] ex, got;
      build_boundary(img);
      q.delete(); qs.delete();
      send_frame(img, 1'b1);
      total++; if (q.size() != 6) begin bad++; $display("FAIL bound_count got=%0d required=6", q.size()); end
      for (int i = 0; i < 6; i++) begin
         ex  = {em[i], ed[i], (i % 3) == 2, i == 5};
         got = (i < q.size()) ? q[i] : 'x;
         total++; if (got !== ex) begin bad++; $display("FAIL bound_res%0d got=%h required=%h", i, got, ex); end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] img [N];
      logic [7:0] em [6] = '{8'd127, 8'd127, 8'd0, 8'd127, 8'd127, 8'd0};
      logic [7:0] es [6] = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
      logic [7:0] got;
      foreach (img[i]) img[i] = ((i % W) >= 2) ? 8'd255 : 8'd0;
      q.delete(); qs.delete();
      send_frame(img, 1'b1);
      total++; if (qs.size() != 6) begin bad++; $display("FAIL sat_count got=%0d required=6", qs.size()); end
      for (int i = 0; i < 6; i++) begin
         got = (i < qs.size()) ? qs[i] : 'x;
         total++; if (got !== es[i]) begin bad++; $display("FAIL sat_mag%0d got=%0d required=%0d", i, got, es[i]); end
         got = (i < q.size()) ? q[i][17:10] : 'x;
         total++; if (got !== em[i]) begin bad++; $display("FAIL shift3_mag%0d got=%0d required=%0d", i, got, em[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] img [N];
      logic [7:0] em [6] = '{8'd60, 8'd40, 8'd60, 8'd20, 8'd20, 8'd20};
      logic [7:0] ed [6] = '{8'd0, 8'd90, 8'd0, 8'd45, 8'd90, 8'd135};
      logic [17:0] ex, got;
      build_boundary(img);
      q.delete(); qs.delete();
      fork
         send_frame(img, 1'b1);
         begin
            int n = 0;
            logic [18:0] snap;
            while (q.size() < 2 && n < 400) begin
               @(posedge tclk);
               n++;
            end
            if (q.size() < 2) begin
               total++; bad++;
               $display("FAIL stall_wait got=%0d results required=2", q.size());
            end else begin
               #1 out_ready = 1'b0;
               #1 snap = {out_valid, out_mag, out_dir, out_eol, out_eof};
               total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b required=1", out_valid); end
               repeat (4) begin
                  @(negedge tclk);
                  total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
                  total++;
                  if ({out_valid, out_mag, out_dir, out_eol, out_eof} !== snap) begin
                     bad++;
                     $display("FAIL stall_hold got=%h required=%h",
                              {out_valid, out_mag, out_dir, out_eol, out_eof}, snap);
                  end
               end
               @(posedge tclk);
               #1 out_ready = 1'b1;
            end
         end
      join
      repeat (4) @(posedge tclk);
      #1;
      total++; if (q.size() != 6) begin bad++; $display("FAIL b2b_count got=%0d required=6", q.size()); end
      for (int i = 0; i < 6; i++) begin
         ex  = {em[i], ed[i], (i % 3) == 2, i == 5};
         got = (i < q.size()) ? q[i] : 'x;
         total++; if (got !== ex) begin bad++; $display("FAIL b2b_res%0d got=%h required=%h", i, got, ex); end
      end
   endtask

   task automatic test_sof_and_reset();
      logic [7:0] img [N];
      logic [17:0] ex, got;
      q.delete(); qs.delete();
      for (int i = 0; i < 13; i++) push(8'd10, i == 0);
      push(8'd10, 1'b1);
      total++; if (sof_err !== 1'b1) begin bad++; $display("FAIL sof_err_set got=%b required=1", sof_err); end
      for (int i = 0; i < 9; i++) push(8'd10, 1'b0);
      repeat (6) @(posedge tclk);
      #1;
      total++; if (q.size() != 1) begin bad++; $display("FAIL sof_restart_count got=%0d required=1", q.size()); end
      for (int i = 0; i < 5; i++) push(8'd10, 1'b0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b required=1", out_valid); end
      rst_b = 1'b0;
      q.delete(); qs.delete();
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%b required=0", out_valid); end
      total++; if (sof_err !== 1'b0) begin bad++; $display("FAIL rst_sof_err_clr got=%b required=0", sof_err); end
      repeat (2) @(posedge tclk);
      #1 rst_b = 1'b1;
      @(posedge tclk);
      #1;
      foreach (img[i]) img[i] = 8'd20;
      send_frame(img, 1'b0);
      total++; if (q.size() != 6) begin bad++; $display("FAIL post_rst_count got=%0d required=6", q.size()); end
      for (int i = 0; i < 6; i++) begin
         ex  = {8'd0, 8'd0, (i % 3) == 2, i == 5};
         got = (i < q.size()) ? q[i] : 'x;
         total++; if (got !== ex) begin bad++; $display("FAIL post_rst_res%0d got=%h required=%h", i, got, ex); end
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_vstep();
      test_hstep();
      test_diag();
      test_dir_boundary();
      test_saturate();
      test_back_to_back();
      test_sof_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
